// File: rtl/bus_pkg.sv
// Shared bus definitions for the CPU, the memory model and the memory bus arbiter.
// State encodings, read/write strobe values and default bus widths.
package bus_pkg;

  localparam int AW_DEFAULT = 32;
  localparam int DW_DEFAULT = 32;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } bus_state_e;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-way round-robin picker: chooses a winner from the live requests and the last grant.
// Purely combinational; the pointer register lives in the arbiter.
module rr_pick2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic lastGrant_i,
  output logic valid_o,
  output logic winner_o
);

  // On a tie the port that did not win last time goes first.
  always_comb begin
    valid_o  = req0_i | req1_i;
    winner_o = 1'b0;
    if (req0_i && req1_i) begin
      winner_o = ~lastGrant_i;
    end else if (req1_i) begin
      winner_o = 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the CPU (port 0) and a secondary master (port 1).
// Round-robin, one transaction at a time, fixed memory latency, req/ack handshake.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int AW          = AW_DEFAULT,
  parameter int DW          = DW_DEFAULT,
  parameter int MEM_LATENCY = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          rw0,
  input  logic          rw1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          busy,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_datao,
  output logic          mem_rw,
  input  logic [DW-1:0] mem_data
);

  localparam int CW = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

  bus_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lastGrant_q, lastGrant_d;
  logic          owner_q, owner_d;
  logic          rwLat_q, rwLat_d;
  logic [AW-1:0] addrLat_q, addrLat_d;
  logic [DW-1:0] wdataLat_q, wdataLat_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic pickValid;
  logic pickWinner;

  rr_pick2 u_pick (
    .req0_i      (req0),
    .req1_i      (req1),
    .lastGrant_i (lastGrant_q),
    .valid_o     (pickValid),
    .winner_o    (pickWinner)
  );

  // lastGrant resets to 1 so that port 0 takes the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lastGrant_q <= 1'b1;
      owner_q     <= 1'b0;
      rwLat_q     <= RW_READ;
      addrLat_q   <= '0;
      wdataLat_q  <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lastGrant_q <= lastGrant_d;
      owner_q     <= owner_d;
      rwLat_q     <= rwLat_d;
      addrLat_q   <= addrLat_d;
      wdataLat_q  <= wdataLat_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  // Requests are only looked at in IDLE; BUSY runs purely off the latched copies.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lastGrant_d = lastGrant_q;
    owner_d     = owner_q;
    rwLat_d     = rwLat_q;
    addrLat_d   = addrLat_q;
    wdataLat_d  = wdataLat_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (pickValid) begin
          state_d     = ST_BUSY;
          owner_d     = pickWinner;
          lastGrant_d = pickWinner;
          cnt_d       = CNT_INIT;
          rwLat_d     = pickWinner ? rw1 : rw0;
          addrLat_d   = pickWinner ? addr1 : addr0;
          wdataLat_d  = pickWinner ? wdata1 : wdata0;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_ACK;
          if (rwLat_q == RW_READ) begin
            if (owner_q) begin
              rdata1_d = mem_data;
            end else begin
              rdata0_d = mem_data;
            end
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign gnt0        = busy && !owner_q;
  assign gnt1        = busy && owner_q;
  assign ack0        = (state_q == ST_ACK) && !owner_q;
  assign ack1        = (state_q == ST_ACK) && owner_q;
  assign mem_rw      = (state_q == ST_BUSY) && (rwLat_q == RW_WRITE);
  assign mem_address = addrLat_q;
  assign mem_datao   = wdataLat_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one instance at MEM_LATENCY=2, one at MEM_LATENCY=1.
// Inputs change and outputs are checked on the falling clock edge.
module tb_mem_bus_arbiter;

  logic        clock;
  logic        reset;
  logic        req0, req1, rw0, rw1;
  logic [31:0] addr0, addr1, wdata0, wdata1, rdata0, rdata1;
  logic        ack0, ack1, gnt0, gnt1, busy, memRw;
  logic [31:0] memAddress, memDatao, memData;

  logic        bReq0, bReq1, bRw0, bRw1;
  logic [31:0] bAddr0, bAddr1, bWdata0, bWdata1, bRdata0, bRdata1;
  logic        bAck0, bAck1, bGnt0, bGnt1, bBusy, bMemRw;
  logic [31:0] bMemAddress, bMemDatao, bMemData;

  int assertCount = 0;
  int failCount   = 0;

  mem_bus_arbiter #(.AW(32), .DW(32), .MEM_LATENCY(2)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .rdata0(rdata0), .rdata1(rdata1), .ack0(ack0), .ack1(ack1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
    .mem_address(memAddress), .mem_datao(memDatao), .mem_rw(memRw), .mem_data(memData)
  );

  mem_bus_arbiter #(.AW(32), .DW(32), .MEM_LATENCY(1)) dutFast (
    .clock(clock), .reset(reset),
    .req0(bReq0), .req1(bReq1), .rw0(bRw0), .rw1(bRw1),
    .addr0(bAddr0), .addr1(bAddr1), .wdata0(bWdata0), .wdata1(bWdata1),
    .rdata0(bRdata0), .rdata1(bRdata1), .ack0(bAck0), .ack1(bAck1),
    .gnt0(bGnt0), .gnt1(bGnt1), .busy(bBusy),
    .mem_address(bMemAddress), .mem_datao(bMemDatao), .mem_rw(bMemRw), .mem_data(bMemData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    assertCount++; if ({gnt0, gnt1, ack0, ack1, busy, memRw} !== 6'b0) begin failCount++; $display("[TB] FAIL reset_ctrl: got %b want 000000", {gnt0, gnt1, ack0, ack1, busy, memRw}); end
    assertCount++; if (memAddress !== 32'h0) begin failCount++; $display("[TB] FAIL reset_addr: got %h want 0", memAddress); end
    assertCount++; if (memDatao !== 32'h0) begin failCount++; $display("[TB] FAIL reset_datao: got %h want 0", memDatao); end
    assertCount++; if ({rdata0, rdata1} !== 64'h0) begin failCount++; $display("[TB] FAIL reset_rdata: got %h want 0", {rdata0, rdata1}); end
    assertCount++; if ({bBusy, bAck0, bMemRw, bRdata0} !== 35'h0) begin failCount++; $display("[TB] FAIL reset_fast: got %h want 0", {bBusy, bAck0, bMemRw, bRdata0}); end
  endtask

  task automatic test_read();
    req0 = 1'b1; rw0 = 1'b0; addr0 = 32'h10; memData = 32'hDEADBEEF;
    for (int k = 1; k <= 3; k++) begin
      step();
      assertCount++; if (gnt1 !== 1'b0) begin failCount++; $display("[TB] FAIL rd_gnt1 c%0d: got %b want 0", k, gnt1); end
      assertCount++; if (memRw !== 1'b0) begin failCount++; $display("[TB] FAIL rd_memrw c%0d: got %b want 0", k, memRw); end
      assertCount++; if (ack0 !== (k == 3)) begin failCount++; $display("[TB] FAIL rd_ack0 c%0d: got %b want %b", k, ack0, (k == 3)); end
      if (k < 3) begin
        assertCount++; if (memAddress !== 32'h10) begin failCount++; $display("[TB] FAIL rd_addr c%0d: got %h want 10", k, memAddress); end
      end
    end
    assertCount++; if (rdata0 !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL rd_data: got %h want deadbeef", rdata0); end
    req0 = 1'b0; memData = 32'h0;
    step();
    assertCount++; if ({busy, ack0} !== 2'b00) begin failCount++; $display("[TB] FAIL rd_idle: got %b want 00", {busy, ack0}); end
    assertCount++; if (rdata0 !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL rd_hold: got %h want deadbeef", rdata0); end
  endtask

  task automatic test_write();
    int rwCycles = 0;
    int ackCycles = 0;
    req1 = 1'b1; rw1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h1234; memData = 32'hFFFFFFFF;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (memRw) rwCycles++;
      if (ack1) ackCycles++;
      assertCount++; if (gnt1 !== 1'b1) begin failCount++; $display("[TB] FAIL wr_gnt1 c%0d: got %b want 1", k, gnt1); end
      if (k < 3) begin
        assertCount++; if (memDatao !== 32'h1234) begin failCount++; $display("[TB] FAIL wr_datao c%0d: got %h want 1234", k, memDatao); end
        assertCount++; if (memAddress !== 32'h20) begin failCount++; $display("[TB] FAIL wr_addr c%0d: got %h want 20", k, memAddress); end
      end
    end
    assertCount++; if (ack1 !== 1'b1) begin failCount++; $display("[TB] FAIL wr_ack1: got %b want 1", ack1); end
    req1 = 1'b0;
    step();
    assertCount++; if (rwCycles !== 2) begin failCount++; $display("[TB] FAIL wr_rwcycles: got %0d want 2", rwCycles); end
    assertCount++; if (ackCycles !== 1) begin failCount++; $display("[TB] FAIL wr_ackcycles: got %0d want 1", ackCycles); end
    assertCount++; if (rdata1 !== 32'h0) begin failCount++; $display("[TB] FAIL wr_rdata1: got %h want 0", rdata1); end
    assertCount++; if ({memRw, ack1} !== 2'b00) begin failCount++; $display("[TB] FAIL wr_idle: got %b want 00", {memRw, ack1}); end
    assertCount++; if ({memAddress, memDatao} !== {32'h20, 32'h1234}) begin failCount++; $display("[TB] FAIL wr_hold: got %h/%h want 20/1234", memAddress, memDatao); end
  endtask

  task automatic test_round_robin();
    reset = 1'b1;
    step();
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1; rw0 = 1'b0; rw1 = 1'b0;
    addr0 = 32'h100; addr1 = 32'h200; memData = 32'hA5A50F0F;
    for (int k = 1; k <= 16; k++) begin
      step();
      assertCount++; if ((gnt0 & gnt1) !== 1'b0) begin failCount++; $display("[TB] FAIL rr_both_gnt c%0d: got 1 want 0", k); end
      assertCount++; if (ack0 !== (k == 3 || k == 11)) begin failCount++; $display("[TB] FAIL rr_ack0 c%0d: got %b want %b", k, ack0, (k == 3 || k == 11)); end
      assertCount++; if (ack1 !== (k == 7 || k == 15)) begin failCount++; $display("[TB] FAIL rr_ack1 c%0d: got %b want %b", k, ack1, (k == 7 || k == 15)); end
      if (k == 1 || k == 2 || k == 9 || k == 10) begin
        assertCount++; if (gnt0 !== 1'b1 || memAddress !== 32'h100) begin failCount++; $display("[TB] FAIL rr_port0 c%0d: got gnt0=%b addr=%h want 1/100", k, gnt0, memAddress); end
      end
      if (k == 5 || k == 6 || k == 13 || k == 14) begin
        assertCount++; if (gnt1 !== 1'b1 || memAddress !== 32'h200) begin failCount++; $display("[TB] FAIL rr_port1 c%0d: got gnt1=%b addr=%h want 1/200", k, gnt1, memAddress); end
      end
      if (k == 15) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL rr_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_abort();
    req0 = 1'b1; rw0 = 1'b1; addr0 = 32'h30; wdata0 = 32'h55;
    step();
    step();
    assertCount++; if ({gnt0, memRw} !== 2'b11) begin failCount++; $display("[TB] FAIL ab_busy: got %b want 11", {gnt0, memRw}); end
    reset = 1'b1; req0 = 1'b0;
    step();
    reset = 1'b0;
    assertCount++; if ({ack0, ack1, memRw, gnt0, busy} !== 5'b0) begin failCount++; $display("[TB] FAIL ab_ctrl: got %b want 00000", {ack0, ack1, memRw, gnt0, busy}); end
    assertCount++; if ({memAddress, memDatao} !== 64'h0) begin failCount++; $display("[TB] FAIL ab_bus: got %h/%h want 0/0", memAddress, memDatao); end
    assertCount++; if (rdata0 !== 32'h0) begin failCount++; $display("[TB] FAIL ab_rdata0: got %h want 0", rdata0); end
    req0 = 1'b1; req1 = 1'b1; rw0 = 1'b0; rw1 = 1'b0; addr0 = 32'h34; addr1 = 32'h38;
    step();
    assertCount++; if ({gnt0, gnt1} !== 2'b10) begin failCount++; $display("[TB] FAIL ab_tie: got %b want 10", {gnt0, gnt1}); end
    assertCount++; if (memAddress !== 32'h34) begin failCount++; $display("[TB] FAIL ab_addr: got %h want 34", memAddress); end
    step();
    step();
    assertCount++; if (ack0 !== 1'b1) begin failCount++; $display("[TB] FAIL ab_ack0: got %b want 1", ack0); end
    req0 = 1'b0; req1 = 1'b0;
    step();
  endtask

  task automatic test_req_drop();
    req0 = 1'b1; rw0 = 1'b0; addr0 = 32'h40; memData = 32'h0BADF00D;
    step();
    assertCount++; if (memAddress !== 32'h40) begin failCount++; $display("[TB] FAIL drop_addr1: got %h want 40", memAddress); end
    req0 = 1'b0; addr0 = 32'h44;
    step();
    assertCount++; if (memAddress !== 32'h40) begin failCount++; $display("[TB] FAIL drop_addr2: got %h want 40", memAddress); end
    step();
    assertCount++; if (ack0 !== 1'b1) begin failCount++; $display("[TB] FAIL drop_ack0: got %b want 1", ack0); end
    assertCount++; if (rdata0 !== 32'h0BADF00D) begin failCount++; $display("[TB] FAIL drop_rdata: got %h want 0badf00d", rdata0); end
    step();
    assertCount++; if ({busy, ack0} !== 2'b00) begin failCount++; $display("[TB] FAIL drop_idle: got %b want 00", {busy, ack0}); end
  endtask

  // Memory data changes every cycle, so each read must capture its own single bus cycle.
  task automatic test_back_to_back();
    bReq0 = 1'b1; bRw0 = 1'b0; bAddr0 = 32'h50; bMemData = 32'hC0DE0000;
    for (int k = 1; k <= 9; k++) begin
      step();
      assertCount++; if (bAck0 !== (k % 3 == 2)) begin failCount++; $display("[TB] FAIL b2b_ack0 c%0d: got %b want %b", k, bAck0, (k % 3 == 2)); end
      if (k % 3 == 1) begin
        assertCount++; if ({bGnt0, bMemAddress} !== {1'b1, 32'h50}) begin failCount++; $display("[TB] FAIL b2b_bus c%0d: got gnt=%b addr=%h want 1/50", k, bGnt0, bMemAddress); end
      end
      if (k % 3 == 2) begin
        assertCount++; if (bRdata0 !== 32'hC0DE0000 + 32'(k - 1)) begin failCount++; $display("[TB] FAIL b2b_rdata c%0d: got %h want %h", k, bRdata0, 32'hC0DE0000 + 32'(k - 1)); end
      end
      bMemData = 32'hC0DE0000 + 32'(k);
      if (k == 8) bReq0 = 1'b0;
    end
    assertCount++; if (bBusy !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_idle: got %b want 0", bBusy); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; memData = '0;
    bReq0 = 1'b0; bReq1 = 1'b0; bRw0 = 1'b0; bRw1 = 1'b0;
    bAddr0 = '0; bAddr1 = '0; bWdata0 = '0; bWdata1 = '0; bMemData = '0;
    step();
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_reset_abort();
    test_req_drop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
